// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner with frame snapshot, anti-ghost
// blanking, per-field blink, leading-zero blanking and colon blink.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hour_tens,
    input  logic [3:0] hour_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic [2:0] blink_mask,
    input  logic       lz_blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [23:0]   snap_digit_q, snap_digit_d;
    logic [2:0]    snap_mask_q, snap_mask_d;
    logic          snap_lz_q, snap_lz_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick, wrap, in_blank, field_blink, digit_off;
    logic [3:0]    digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'b1000000;
            4'd1:    bcd_to_seg = 7'b1111001;
            4'd2:    bcd_to_seg = 7'b0100100;
            4'd3:    bcd_to_seg = 7'b0110000;
            4'd4:    bcd_to_seg = 7'b0011001;
            4'd5:    bcd_to_seg = 7'b0010010;
            4'd6:    bcd_to_seg = 7'b0000010;
            4'd7:    bcd_to_seg = 7'b1111000;
            4'd8:    bcd_to_seg = 7'b0000000;
            4'd9:    bcd_to_seg = 7'b0010000;
            default: bcd_to_seg = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        tick     = (presc_q == PW'(SCAN_DIV - 1));
        wrap     = tick && (idx_q == 3'd5);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

        frame_d      = frame_q;
        phase_d      = phase_q;
        snap_digit_d = snap_digit_q;
        snap_mask_d  = snap_mask_q;
        snap_lz_d    = snap_lz_q;
        if (wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
            snap_digit_d = {sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens};
            snap_mask_d  = blink_mask;
            snap_lz_d    = lz_blank;
        end

        // Index 0 is hour_tens in the low nibble of the snapshot; fields pair up by index.
        case (idx_q)
            3'd0:    begin digit = snap_digit_q[3:0];   field_blink = snap_mask_q[2]; end
            3'd1:    begin digit = snap_digit_q[7:4];   field_blink = snap_mask_q[2]; end
            3'd2:    begin digit = snap_digit_q[11:8];  field_blink = snap_mask_q[1]; end
            3'd3:    begin digit = snap_digit_q[15:12]; field_blink = snap_mask_q[1]; end
            3'd4:    begin digit = snap_digit_q[19:16]; field_blink = snap_mask_q[0]; end
            default: begin digit = snap_digit_q[23:20]; field_blink = snap_mask_q[0]; end
        endcase

        in_blank  = (32'(presc_q) < BLANK_CYCLES);
        digit_off = (field_blink && phase_q)
                  || ((idx_q == 3'd0) && snap_lz_q && (snap_digit_q[3:0] == 4'd0));

        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (!in_blank) begin
            an_d = ~(6'b100000 >> idx_q);
            if (!digit_off) begin
                seg_d = bcd_to_seg(digit);
                dp_d  = !(((idx_q == 3'd1) || (idx_q == 3'd3)) && !phase_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            snap_digit_q <= '0;
            snap_mask_q  <= '0;
            snap_lz_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= '1;
            dp_q         <= 1'b1;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            snap_digit_q <= snap_digit_d;
            snap_mask_q  <= snap_mask_d;
            snap_lz_q    <= snap_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_CYCLES, default 500: clk cycles at the start of each slot during which all digits are off (anti-ghosting); legal range 0..SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 100: complete 6-digit frames per blink half-period; legal range 1..255.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clock is clk.
REQ-006 hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones  input  4 each  BCD digits from the time counters.
REQ-007 blink_mask  input  3  blink enable per field: bit2 hours, bit1 minutes, bit0 seconds.
REQ-008 lz_blank  input  1  when high, blank hour_tens if it equals 0.
REQ-009 an  output  6  digit enables, active-low; an[5] is the leftmost digit (hour_tens), an[0] is the rightmost digit (sec_ones).
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; the cycle where it equals SCAN_DIV-1 is the slot tick.
REQ-013 The digit index SHALL advance 0->1->...->5->0 on each slot tick. Index 0 selects hour_tens (an[5]) and index 5 selects sec_ones (an[0]).
REQ-014 On the slot tick where the index wraps 5->0, all six BCD inputs, blink_mask and lz_blank SHALL be captured into a snapshot register. The whole following frame displays only the snapshot, so input changes mid-frame never tear the display.
REQ-015 The frame counter SHALL increment on each 5->0 wrap. When it reaches BLINK_FRAMES-1 it SHALL clear and blink_phase SHALL toggle.
REQ-016 While prescaler < BLANK_CYCLES, an SHALL be 6'b111111, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-017 Outside the blank window, exactly one an bit (the selected digit) SHALL be 0.
REQ-018 Segment decode (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10..15 SHALL display '-' = 0111111.
REQ-019 A digit SHALL be blanked (seg=1111111, dp=1, its an bit still 0) when either condition holds:
- its field bit in the snapshot blink_mask is 1 and blink_phase is 1;
- it is hour_tens, snapshot lz_blank is 1 and snapshot hour_tens is 0.
REQ-020 dp SHALL be 0 on index 1 (hour_ones) and index 3 (min_ones) when blink_phase is 0; otherwise dp SHALL be 1 (colon blink). A blanked digit SHALL override this with dp=1.
REQ-021 an, seg and dp SHALL be registered. They reflect the prescaler/index state of the previous cycle (1-cycle latency).
REQ-022 The prescaler, index and frame counter SHALL use the minimum widths that hold their ranges. No arithmetic overflow is permitted for any legal parameter value.

Reset
REQ-023 While reset is high, the following SHALL hold:
- prescaler=0, index=0, frame counter=0, blink_phase=0;
- snapshot digits=0, snapshot blink_mask=0, snapshot lz_blank=0;
- an=111111, seg=1111111, dp=1.
REQ-024 After reset is released, the first frame SHALL display the all-zero snapshot until the first 5->0 wrap.
REQ-025 Asserting reset mid-frame SHALL abort the scan immediately (asynchronously). After release, scanning SHALL restart from index 0 with prescaler 0.

Verification (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2)
REQ-026 Reset release, inputs 1,2,3,4,5,6, blink_mask=0 -> first frame shows 1000000 on every digit. After the first wrap, the frame shows, slot by slot:
- an=011111 seg=1111001;
- an=101111 seg=0100100 dp=0;
- ... through an=111110 seg=0000010.
REQ-027 Each slot -> exactly 1 cycle of an=111111, then 3 cycles with a single an bit low; the index wraps every 24 cycles.
REQ-028 Change min_ones from 4 to 9 mid-frame -> the current frame still shows 4 at index 3; the next frame shows 0010000.
REQ-029 blink_mask=100 -> hour digits are blanked with an still active during blink_phase=1 (frames 3-4, 7-8, ...); dp stays 1 on all digits during those frames.
REQ-030 lz_blank=1, hour_tens=0 -> index 0 seg=1111111. hour_tens=10 -> seg=0111111.
REQ-031 Reset pulsed at index 3 -> outputs go to the reset state in the same cycle. After release, the first enabled digit is an[5], 2 cycles later (1 blank cycle + 1 cycle of register latency).
